// File: rtl/h_chal_trit_expand.sv
// Expands SM3 challenge digests into T Picnic challenge trits, scanning 2-bit pairs
// MSB first, skipping 2'b11, and requesting a rehash whenever a digest runs dry.
module h_chal_trit_expand #(
  parameter int T  = 219,
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [255:0]   hash_in,
  input  logic           hash_valid,
  output logic           rehash_req,
  output logic [255:0]   rehash_seed,
  output logic [2*T-1:0] trits_out,
  output logic [CW-1:0]  trit_count,
  output logic           busy,
  output logic           done
);

  // state     | meaning
  // IDLE      | not requested, outputs hold last (possibly partial) result
  // WAIT_HASH | armed, waiting for the first digest of this run
  // SCAN      | consuming one pair of the latched digest per cycle
  // REQ       | digest exhausted, rehash of rehash_seed requested
  // DONE      | T trits collected, result frozen until start falls
  typedef enum logic [2:0] {
    IDLE,
    WAIT_HASH,
    SCAN,
    REQ,
    DONE
  } state_t;

  localparam logic [CW-1:0] T_CNT = CW'(T);

  state_t         state, state_nxt;
  logic [255:0]   digest, digest_nxt;
  logic [6:0]     pair_idx, pair_idx_nxt;
  logic [255:0]   seed_nxt;
  logic           req_nxt;
  logic [2*T-1:0] trits_nxt;
  logic [CW-1:0]  cnt_nxt;
  logic           busy_nxt;
  logic           done_nxt;

  logic [7:0]     pair_lsb;
  logic [1:0]     pair;
  logic           pair_ok;
  logic [CW-1:0]  cnt_inc;

  // pair k sits at digest[255-2k:254-2k]; 254-2k == 2*(~k) for a 7-bit k
  assign pair_lsb = {~pair_idx, 1'b0};
  assign pair     = digest[pair_lsb +: 2];
  assign pair_ok  = (pair != 2'b11);
  assign cnt_inc  = trit_count + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      digest      <= '0;
      pair_idx    <= '0;
      rehash_seed <= '0;
      rehash_req  <= 1'b0;
      trits_out   <= '0;
      trit_count  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      digest      <= digest_nxt;
      pair_idx    <= pair_idx_nxt;
      rehash_seed <= seed_nxt;
      rehash_req  <= req_nxt;
      trits_out   <= trits_nxt;
      trit_count  <= cnt_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    digest_nxt   = digest;
    pair_idx_nxt = pair_idx;
    seed_nxt     = rehash_seed;
    req_nxt      = rehash_req;
    trits_nxt    = trits_out;
    cnt_nxt      = trit_count;
    busy_nxt     = busy;
    done_nxt     = done;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WAIT_HASH;
          trits_nxt = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
        end
      end

      WAIT_HASH: begin
        if (!start) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          req_nxt   = 1'b0;
          done_nxt  = 1'b0;
        end else if (hash_valid) begin
          state_nxt    = SCAN;
          digest_nxt   = hash_in;
          pair_idx_nxt = '0;
        end
      end

      SCAN: begin
        if (!start) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          req_nxt   = 1'b0;
          done_nxt  = 1'b0;
        end else begin
          if (pair_ok) begin
            trits_nxt[{trit_count, 1'b0} +: 2] = pair;
            cnt_nxt = cnt_inc;
          end
          // completing the last trit wins over running off the digest end
          if (pair_ok && (cnt_inc == T_CNT)) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else if (pair_idx == 7'd127) begin
            state_nxt = REQ;
            seed_nxt  = digest;
            req_nxt   = 1'b1;
          end else begin
            pair_idx_nxt = pair_idx + 7'd1;
          end
        end
      end

      REQ: begin
        if (!start) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          req_nxt   = 1'b0;
          done_nxt  = 1'b0;
        end else if (hash_valid) begin
          state_nxt    = SCAN;
          digest_nxt   = hash_in;
          pair_idx_nxt = '0;
          req_nxt      = 1'b0;
        end
      end

      DONE: begin
        if (!start) begin
          state_nxt = IDLE;
          done_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        req_nxt   = 1'b0;
        done_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_h_chal_trit_expand.sv
// Randomized bench for h_chal_trit_expand against a digest-level trit model.
module tb_h_chal_trit_expand;
  localparam int T  = 219;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [255:0]   hash_in;
  logic           hash_valid;
  logic           rehash_req;
  logic [255:0]   rehash_seed;
  logic [2*T-1:0] trits_out;
  logic [CW-1:0]  trit_count;
  logic           busy;
  logic           done;

  h_chal_trit_expand #(.T(T), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .hash_in(hash_in),
    .hash_valid(hash_valid), .rehash_req(rehash_req), .rehash_seed(rehash_seed),
    .trits_out(trits_out), .trit_count(trit_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0]   digs[$];
  int             exp_cyc[16];
  int             exp_cnt[16];
  logic [2*T-1:0] exp_trits;
  int             n_used;
  bit             exp_done;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_digest(input bit biased);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 128; k++) begin
      d = d << 2;
      if (biased) d[1:0] = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 2));
      else        d[1:0] = 2'($urandom_range(0, 3));
    end
    return d;
  endfunction

  function automatic logic [255:0] rep_1b();
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 32; k++) d = (d << 8) | 256'h1b;
    return d;
  endfunction

  function automatic logic [2*T-1:0] low_trits(input logic [2*T-1:0] v, input int n);
    logic [2*T-1:0] r;
    r = '0;
    for (int j = 0; j < 2 * n; j++) r[j] = v[j];
    return r;
  endfunction

  // Walk digests pair by pair: each pair costs one scan cycle, 3 is skipped,
  // collection stops the moment the T-th trit lands.
  task automatic model_run(input int max_dig);
    int cnt, cyc, p;
    cnt = 0; exp_trits = '0; n_used = 0; exp_done = 0;
    for (int i = 0; i < max_dig && i < digs.size(); i++) begin
      cyc = 0;
      for (int k = 0; k < 128; k++) begin
        p = int'((digs[i] >> (254 - 2 * k)) & 256'd3);
        cyc++;
        if (p != 3) begin
          exp_trits[2 * cnt +: 2] = 2'(p);
          cnt++;
        end
        if (cnt == T) break;
      end
      exp_cyc[i] = cyc;
      exp_cnt[i] = cnt;
      n_used = i + 1;
      if (cnt == T) begin
        exp_done = 1;
        break;
      end
    end
  endtask

  task automatic run_case(input int max_dig, input int hold, input bit do_abort);
    int n;
    bit bad;
    model_run(max_dig);
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    check("start_busy", busy, 1'b1);
    check("start_cnt", trit_count, '0);
    check("start_trits", trits_out, '0);
    for (int i = 0; i < n_used; i++) begin
      @(negedge clk);
      hash_in = digs[i];
      hash_valid = 1'b1;
      @(negedge clk);
      hash_valid = 1'b0;
      hash_in = rand_digest(0);
      n = 0; bad = 0;
      while (!(rehash_req || done) && n < 200) begin
        @(negedge clk);
        n++;
        if (!(rehash_req || done) && (busy !== 1'b1 || done !== 1'b0)) bad = 1;
      end
      check("scan_flags", bad, 1'b0);
      check("scan_cycles", n, exp_cyc[i]);
      check("scan_cnt", trit_count, exp_cnt[i]);
      if (i == n_used - 1 && exp_done) begin
        check("done_flag", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_req", rehash_req, 1'b0);
        check("done_trits", trits_out, exp_trits);
        for (int c = 0; c < hold; c++) begin
          @(negedge clk);
          hash_valid = ($urandom_range(0, 1) == 1);
          hash_in = rand_digest(0);
        end
        @(negedge clk) hash_valid = 1'b0;
        check("hold_done", done, 1'b1);
        check("hold_trits", trits_out, exp_trits);
        check("hold_cnt", trit_count, T);
        start = 1'b0;
        @(negedge clk);
        check("drop_done", done, 1'b0);
        check("drop_busy", busy, 1'b0);
        check("drop_cnt", trit_count, T);
      end else begin
        check("req_flag", rehash_req, 1'b1);
        check("req_seed", rehash_seed, digs[i]);
        check("req_busy", busy, 1'b1);
        check("req_trits", trits_out, low_trits(exp_trits, exp_cnt[i]));
      end
    end
    if (!exp_done && do_abort) begin
      start = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 1'b0);
      check("abort_req", rehash_req, 1'b0);
      check("abort_cnt", trit_count, exp_cnt[n_used - 1]);
    end
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; hash_valid = 1'b0; hash_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_req", rehash_req, 1'b0);
    check("rst_cnt", trit_count, '0);
    check("rst_trits", trits_out, '0);
    check("rst_seed", rehash_seed, '0);
    reset = 1'b1;
    @(negedge clk);

    // all-zero digests: 128 trits, rehash, then 91 more
    digs = {256'd0, 256'd0};
    run_case(2, 5, 1);

    // all-ones digest never yields a trit
    digs = {{256{1'b1}}};
    run_case(1, 0, 1);

    // 0x1B pattern: 96 trits per digest, held in DONE with stray hash pulses
    digs = {rep_1b(), rep_1b(), rep_1b()};
    run_case(3, 20, 1);
    check("pattern_low", trits_out[5:0], 6'b100100);

    for (int r = 0; r < 6; r++) begin
      digs.delete();
      for (int i = 0; i < 10; i++) digs.push_back(rand_digest(r >= 4));
      run_case(10, 3, 1);
    end

    // abort at 50 trits, then re-arm
    digs = {rep_1b()};
    model_run(1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) begin hash_in = digs[0]; hash_valid = 1'b1; end
    @(negedge clk) hash_valid = 1'b0;
    n = 0;
    while (trit_count != 8'd50 && n < 200) begin @(negedge clk); n++; end
    check("abort_reach50", trit_count, 8'd50);
    start = 1'b0;
    hash_valid = 1'b1;
    @(negedge clk) hash_valid = 1'b0;
    check("ab50_busy", busy, 1'b0);
    check("ab50_req", rehash_req, 1'b0);
    check("ab50_cnt", trit_count, 8'd50);
    check("ab50_trits", trits_out, low_trits(exp_trits, 50));
    @(negedge clk) hash_valid = 1'b1;
    @(negedge clk) hash_valid = 1'b0;
    check("idle_hv_cnt", trit_count, 8'd50);
    check("idle_hv_busy", busy, 1'b0);
    start = 1'b1;
    @(negedge clk);
    check("rearm_cnt", trit_count, '0);
    check("rearm_trits", trits_out, '0);
    check("rearm_busy", busy, 1'b1);
    start = 1'b0;
    @(negedge clk);

    // async reset while waiting in REQ
    digs = {rand_digest(0)};
    run_case(1, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("areset_req", rehash_req, 1'b0);
    check("areset_busy", busy, 1'b0);
    check("areset_cnt", trit_count, '0);
    check("areset_trits", trits_out, '0);
    check("areset_seed", rehash_seed, '0);
    start = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) begin hash_in = rand_digest(0); hash_valid = 1'b1; end
    @(negedge clk) hash_valid = 1'b0;
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_cnt", trit_count, '0);
    // start and hash_valid together: hash must be dropped
    start = 1'b1; hash_valid = 1'b1; hash_in = 256'd0;
    @(negedge clk) hash_valid = 1'b0;
    check("simul_busy", busy, 1'b1);
    repeat (5) @(negedge clk);
    check("simul_cnt", trit_count, '0);
    check("simul_busy2", busy, 1'b1);
    check("simul_req", rehash_req, 1'b0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
